// File: rtl/regfile_wb_reader.sv
// regfile_wb_reader
//   Writeback-side register file. Commits results from the execute-stage
//   pipeline register and serves two registered read ports to decode. A
//   writeback committing in the same cycle as a read is forwarded to that
//   read (write-first), so decode never sees stale data. It also counts
//   committed writebacks for debug.
//
// Ports
//   clk             clock, all state updates on posedge
//   rst             synchronous active-high reset
//   wb_write_enable writeback valid
//   wb_rd_sel       destination register index
//   wb_result       value to commit
//   rd_req          read request from decode
//   rs1_sel/rs2_sel read port indices
//   rs1_data/rs2_data registered read data (latency 1)
//   rd_valid        one-cycle pulse per accepted rd_req
//   wb_commit_cnt   committed writeback count, wraps modulo 2^CNT_W
module regfile_wb_reader #(
    parameter int DATA_W   = 32,
    parameter int SEL_W    = 6,
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_write_enable,
    input  logic [SEL_W-1:0]  wb_rd_sel,
    input  logic [DATA_W-1:0] wb_result,
    input  logic              rd_req,
    input  logic [SEL_W-1:0]  rs1_sel,
    input  logic [SEL_W-1:0]  rs2_sel,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rd_valid,
    output logic [CNT_W-1:0]  wb_commit_cnt
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    // One extra bit so NUM_REGS itself is representable when it equals 2^SEL_W.
    localparam logic [SEL_W:0] LP_NUM_REGS = NUM_REGS[SEL_W:0];

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] r_rs1_data;
    logic [DATA_W-1:0] r_rs2_data;
    logic              r_rd_valid;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_wb_in_range;
    logic              w_commit;
    logic [IDX_W-1:0]  w_wb_idx;
    logic              w_rs1_ok;
    logic              w_rs2_ok;
    logic [IDX_W-1:0]  w_rs1_idx;
    logic [IDX_W-1:0]  w_rs2_idx;
    logic [DATA_W-1:0] w_rs1_val;
    logic [DATA_W-1:0] w_rs2_val;

    assign w_wb_in_range = ({1'b0, wb_rd_sel} < LP_NUM_REGS);
    assign w_commit      = wb_write_enable && (wb_rd_sel != '0) && w_wb_in_range;
    assign w_wb_idx      = wb_rd_sel[IDX_W-1:0];

    assign w_rs1_ok  = (rs1_sel != '0) && ({1'b0, rs1_sel} < LP_NUM_REGS);
    assign w_rs2_ok  = (rs2_sel != '0) && ({1'b0, rs2_sel} < LP_NUM_REGS);
    assign w_rs1_idx = rs1_sel[IDX_W-1:0];
    assign w_rs2_idx = rs2_sel[IDX_W-1:0];

    // Read value selection: x0 / out of range -> 0, else same-cycle commit
    // to the same index wins over the stored value.
    always_comb begin
        w_rs1_val = '0;
        w_rs2_val = '0;
        if (w_rs1_ok) begin
            if (w_commit && (wb_rd_sel == rs1_sel)) begin
                w_rs1_val = wb_result;
            end else begin
                w_rs1_val = r_regs[w_rs1_idx];
            end
        end
        if (w_rs2_ok) begin
            if (w_commit && (wb_rd_sel == rs2_sel)) begin
                w_rs2_val = wb_result;
            end else begin
                w_rs2_val = r_regs[w_rs2_idx];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_rd_valid <= 1'b0;
            r_cnt      <= '0;
        end else begin
            if (w_commit) begin
                r_regs[w_wb_idx] <= wb_result;
                r_cnt            <= r_cnt + CNT_W'(1);
            end
            r_rd_valid <= rd_req;
            if (rd_req) begin
                r_rs1_data <= w_rs1_val;
                r_rs2_data <= w_rs2_val;
            end
        end
    end

    assign rs1_data      = r_rs1_data;
    assign rs2_data      = r_rs2_data;
    assign rd_valid      = r_rd_valid;
    assign wb_commit_cnt = r_cnt;

endmodule
